inst_fetch: RTL

- Instruction fetch front end; the producer side of the decoder's instruction input.
- Holds the PC and issues word reads to instruction memory over a request/response interface.
- Buffers returned words with their PC and fault status, and presents them to the decoder with a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap) by flushing buffered and in-flight fetches.

---
 rtl/core_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/inst_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: instruction words, fetch faults and the
// fetch buffer entry handed from fetch to decode.
package core_pkg;

  typedef logic [31:0] Instruction;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    MISALIGNED = 2'd1,
    ACCESS     = 2'd2
  } FetchFault;

  localparam Instruction NOP_INST = 32'h0000_0013;

  typedef struct packed {
    Instruction  inst;
    logic [31:0] pc;
    FetchFault   fault;
  } FetchEntry;

  typedef enum logic [1:0] {
    FETCH,
    MISAL,
    HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, occupancy count and
// simultaneous push/pop (legal even when full).
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC, credit-limited imem requests,
// redirect flush with stale-response dropping, and a decode buffer.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output Instruction  inst,
  output logic [31:0] inst_pc,
  output FetchFault   inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(2*DEPTH+1);
  typedef logic [OW-1:0] ocnt_t;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ocnt_t        out_q, out_d;
  ocnt_t        drop_q, drop_d;
  ocnt_t        used;

  FetchEntry     buf_head, buf_in;
  logic [CW-1:0] buf_cnt, tag_cnt;
  logic          buf_empty, buf_full;
  logic          tag_empty, tag_full;
  logic [31:0]   tag_head;

  logic buf_push, buf_pop;
  logic tag_push, tag_pop;
  logic req_hs, rsp_live, credit_ok;

  assign rsp_live = imem_rsp_valid && (drop_q == '0);
  assign used     = ocnt_t'(buf_cnt) + out_q - drop_q;
  // The second term caps stale + live requests at DEPTH, which
  // bounds drop and lets the tag queue stay DEPTH deep.
  assign credit_ok = (used < ocnt_t'(DEPTH)) &&
                     (out_q < ocnt_t'(DEPTH));

  assign imem_req_addr = pc_q;
  assign inst_valid    = !buf_empty;
  assign inst          = inst_valid ? buf_head.inst : '0;
  assign inst_pc       = inst_valid ? buf_head.pc : '0;
  assign inst_fault    = inst_valid ? buf_head.fault : NONE;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // FSM next state: redirect overrides, faults halt fetching.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) state_d = MISAL;
      else                           state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (rsp_live && imem_rsp_err) state_d = HALTED;
        MISAL:   state_d = HALTED;
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM outputs: request issue and buffer enqueue per state.
  always_comb begin
    imem_req_valid = 1'b0;
    buf_push       = 1'b0;
    buf_in         = '{inst: NOP_INST, pc: pc_q, fault: MISALIGNED};
    unique case (state_q)
      FETCH: begin
        imem_req_valid = rst_n && credit_ok;
        buf_push       = rsp_live && !redirect_valid;
        if (imem_rsp_err)
          buf_in = '{inst: NOP_INST, pc: tag_head, fault: ACCESS};
        else
          buf_in = '{inst: imem_rsp_data, pc: tag_head, fault: NONE};
      end
      MISAL:   buf_push = !redirect_valid;
      default: ;
    endcase
  end

  // PC, in-flight and drop bookkeeping.
  always_comb begin
    req_hs   = imem_req_valid && imem_req_ready;
    buf_pop  = inst_valid && inst_ready && !redirect_valid;
    tag_push = req_hs && !redirect_valid;
    tag_pop  = rsp_live && !redirect_valid;
    pc_d     = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (req_hs)    pc_d = pc_q + 32'd4;
    out_d  = out_q + ocnt_t'(req_hs) - ocnt_t'(imem_rsp_valid);
    drop_d = drop_q;
    if (redirect_valid)
      drop_d = out_d;
    else if (imem_rsp_valid && drop_q != '0)
      drop_d = drop_q - ocnt_t'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(FetchEntry))) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_cnt),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_tag (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (tag_push),
    .push_data (pc_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_cnt),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    drop_q <= out_q);
  a_req_align: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_valid |-> imem_req_addr[1:0] == 2'b00);
  a_tag_live: assert property (@(posedge clk) disable iff (!rst_n)
    tag_cnt == CW'(out_q - drop_q));
  a_tag_ok: assert property (@(posedge clk) disable iff (!rst_n)
    !(tag_pop && tag_empty) && !(tag_push && tag_full));
  a_buf_ok: assert property (@(posedge clk) disable iff (!rst_n)
    !(buf_push && buf_full && !buf_pop));

endmodule
